// File: rtl/microcpu_pkg.sv
// Shared MicroCPU definitions: default bus widths, opcodes used by programs,
// and the boot-loader state encoding.
package microcpu_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefAddrW = 8;

  localparam logic [7:0] OpNop = 8'h00;
  localparam logic [7:0] OpLdi = 8'h02;
  localparam logic [7:0] OpJmp = 8'h0C;
  localparam logic [7:0] OpOut = 8'h0D;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StLoad = 1'b1
  } state_e;

endpackage

// File: rtl/progmem_ram.sv
// Single-port synchronous RAM with registered read; maps onto block RAM.
module progmem_ram #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 256,
  parameter int unsigned AddrW = 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/progmem_boot.sv
// MicroCPU program memory: byte-wise boot loader writes a RAM, CPU fetches
// read it back with one-cycle latency while no load is in progress.
module progmem_boot
  import microcpu_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] IP,
  input  logic              FETCH_EN,
  output logic [DATA_W-1:0] DATA,
  output logic              DATA_VALID,
  input  logic              LD_START,
  input  logic [7:0]        LD_BYTE,
  input  logic              LD_STB,
  output logic              LD_BUSY,
  output logic              LD_DONE,
  output logic              LD_ERR,
  output logic              CPU_HOLD,
  output logic [ADDR_W:0]   LD_COUNT
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned RAW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [BCW-1:0]  LastByte = BCW'(NBYTES - 1);
  localparam logic [ADDR_W:0] DepthW   = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [BCW-1:0]    bcnt_q, bcnt_d;
  logic [DATA_W-1:0] asm_q, asm_d, asm_shift;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              zero_q, zero_d;
  logic              valid_q, valid_d;
  logic              we, re, ip_ok, full, in_load;
  logic [RAW-1:0]    ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  assign in_load   = (state_q == StLoad);
  assign ip_ok     = ({1'b0, IP} < DepthW);
  // Word count doubles as the write address, so "full" means DEPTH words written.
  assign full      = (cnt_q == DepthW);
  assign asm_shift = (asm_q << 8) | DATA_W'(LD_BYTE);

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (LD_START) state_d = StLoad;
      StLoad: if (LD_START || (LD_STB && full)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Loader datapath and fetch controls
  always_comb begin
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    err_d   = err_q;
    done_d  = 1'b0;
    we      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (LD_START) begin
          cnt_d  = '0;
          bcnt_d = '0;
          asm_d  = '0;
          err_d  = 1'b0;
        end
      end
      StLoad: begin
        if (LD_START) begin
          // A pending partial word makes the load a failure.
          bcnt_d = '0;
          if (bcnt_q != '0) err_d = 1'b1;
          else              done_d = 1'b1;
        end else if (LD_STB) begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            asm_d = asm_shift;
            if (bcnt_q == LastByte) begin
              we     = 1'b1;
              cnt_d  = cnt_q + 1'b1;
              bcnt_d = '0;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end
        end
      end
      default: ;
    endcase

    re      = !in_load && FETCH_EN && ip_ok;
    valid_d = !in_load && FETCH_EN;
    zero_d  = zero_q;
    if (in_load)       zero_d = 1'b1;
    else if (FETCH_EN) zero_d = !ip_ok;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q   <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      err_q   <= err_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  assign ram_addr = in_load ? cnt_q[RAW-1:0] : IP[RAW-1:0];

  progmem_ram #(
    .Width (DATA_W),
    .Depth (DEPTH),
    .AddrW (RAW)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (we),
    .re_i    (re),
    .addr_i  (ram_addr),
    .wdata_i (asm_shift),
    .rdata_o (ram_rdata)
  );

  // RAM output register is not reset, so a zero flag masks it to NOP.
  assign DATA       = zero_q ? DATA_W'(OpNop) : ram_rdata;
  assign DATA_VALID = valid_q;
  assign LD_BUSY    = in_load;
  assign CPU_HOLD   = in_load;
  assign LD_DONE    = done_q;
  assign LD_ERR     = err_q;
  assign LD_COUNT   = cnt_q;

endmodule

// File: tb/tb_progmem_boot.sv
// Bench for progmem_boot: two instances (DEPTH 200 and 4) share stimulus and
// are checked every cycle against a byte-list program-memory model.
module tb_progmem_boot;

  localparam int NB = 2;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [7:0] IP = '0;
  logic       FETCH_EN = 1'b0;
  logic       LD_START = 1'b0;
  logic       LD_STB = 1'b0;
  logic [7:0] LD_BYTE = '0;

  logic [15:0] data_a, data_b;
  logic        valid_a, valid_b, busy_a, busy_b, done_a, done_b;
  logic        err_a, err_b, hold_a, hold_b;
  logic [8:0]  cnt_a, cnt_b;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;

  always #5 CLK = ~CLK;

  progmem_boot #(.DATA_W(16), .ADDR_W(8), .DEPTH(200)) u_dut_a (
    .CLK (CLK), .RESET (RESET), .IP (IP), .FETCH_EN (FETCH_EN),
    .DATA (data_a), .DATA_VALID (valid_a), .LD_START (LD_START),
    .LD_BYTE (LD_BYTE), .LD_STB (LD_STB), .LD_BUSY (busy_a), .LD_DONE (done_a),
    .LD_ERR (err_a), .CPU_HOLD (hold_a), .LD_COUNT (cnt_a)
  );

  progmem_boot #(.DATA_W(16), .ADDR_W(8), .DEPTH(4)) u_dut_b (
    .CLK (CLK), .RESET (RESET), .IP (IP), .FETCH_EN (FETCH_EN),
    .DATA (data_b), .DATA_VALID (valid_b), .LD_START (LD_START),
    .LD_BYTE (LD_BYTE), .LD_STB (LD_STB), .LD_BUSY (busy_b), .LD_DONE (done_b),
    .LD_ERR (err_b), .CPU_HOLD (hold_b), .LD_COUNT (cnt_b)
  );

  // Model: memory image plus list of bytes received for the pending word.
  int          depth [2] = '{200, 4};
  logic [15:0] m_mem   [2][256];
  bit          m_known [2][256];
  logic [7:0]  m_buf   [2][NB];
  int          m_nb [2];
  int          m_cnt [2];
  bit          m_load [2], m_err [2], m_done [2], m_valid [2], m_dknown [2];
  logic [15:0] m_data [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_load[d] = 0; m_nb[d] = 0; m_cnt[d] = 0; m_err[d] = 0; m_done[d] = 0;
      m_valid[d] = 0; m_data[d] = '0; m_dknown[d] = 1;
    end
  endtask

  task automatic model_step(input int d);
    logic [15:0] word;
    m_done[d] = 0;
    if (m_load[d]) begin
      m_data[d] = '0; m_dknown[d] = 1; m_valid[d] = 0;
    end else if (FETCH_EN) begin
      m_valid[d] = 1;
      if (int'(IP) < depth[d]) begin
        m_data[d] = m_mem[d][IP]; m_dknown[d] = m_known[d][IP];
      end else begin
        m_data[d] = '0; m_dknown[d] = 1;
      end
    end else begin
      m_valid[d] = 0;
    end
    if (!m_load[d]) begin
      if (LD_START) begin
        m_load[d] = 1; m_nb[d] = 0; m_cnt[d] = 0; m_err[d] = 0;
      end
    end else if (LD_START) begin
      m_load[d] = 0;
      if (m_nb[d] != 0) m_err[d] = 1;
      else              m_done[d] = 1;
      m_nb[d] = 0;
    end else if (LD_STB) begin
      if (m_cnt[d] == depth[d]) begin
        m_err[d] = 1; m_load[d] = 0;
      end else if (m_nb[d] == NB - 1) begin
        word = '0;
        for (int k = 0; k < m_nb[d]; k++) word = (word << 8) | 16'(m_buf[d][k]);
        word = (word << 8) | 16'(LD_BYTE);
        m_mem[d][m_cnt[d]] = word; m_known[d][m_cnt[d]] = 1;
        m_cnt[d]++; m_nb[d] = 0;
      end else begin
        m_buf[d][m_nb[d]] = LD_BYTE; m_nb[d]++;
      end
    end
  endtask

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic cmp(input int d, input logic [15:0] data, input logic valid, input logic busy,
                     input logic done, input logic err, input logic hold, input logic [8:0] cnt);
    chk($sformatf("busy_d%0d", d), busy, m_load[d]);
    chk($sformatf("hold_d%0d", d), hold, m_load[d]);
    chk($sformatf("done_d%0d", d), done, m_done[d]);
    chk($sformatf("err_d%0d", d), err, m_err[d]);
    chk($sformatf("valid_d%0d", d), valid, m_valid[d]);
    chk($sformatf("count_d%0d", d), cnt, m_cnt[d]);
    if (m_dknown[d]) chk($sformatf("data_d%0d", d), data, m_data[d]);
  endtask

  always @(negedge CLK) begin
    if (RESET) begin
      cmp(0, data_a, valid_a, busy_a, done_a, err_a, hold_a, cnt_a);
      cmp(1, data_b, valid_b, busy_b, done_b, err_b, hold_b, cnt_b);
      if (done_a) done_seen++;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start();
    LD_START = 1'b1; tick(); LD_START = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    LD_BYTE = b; LD_STB = 1'b1; tick(); LD_STB = 1'b0;
  endtask

  int d0;
  logic [15:0] t6_exp [3] = '{16'hA1A2, 16'hA3A4, 16'hA5A6};

  initial begin
    model_reset();
    // Reset then idle fetch
    #50;
    chk("rst_data", data_a, 16'h0000);
    chk("rst_valid", valid_a, 1'b0);
    chk("rst_hold", hold_a, 1'b0);
    chk("rst_count", cnt_a, 9'd0);
    #50;
    RESET = 1'b1; FETCH_EN = 1'b1; IP = 8'd3;
    tick();
    chk("t1_valid", valid_a, 1'b1);

    // Basic load
    d0 = done_seen;
    start();
    send(8'h0D); send(8'h64); send(8'h0C); send(8'h03);
    chk("t2_hold", hold_a, 1'b1);
    start();
    chk("t2_done", done_a, 1'b1);
    chk("t2_count", cnt_a, 9'd2);
    chk("t2_err", err_a, 1'b0);
    IP = 8'd0; tick();
    chk("t2_ip0", data_a, 16'h0D64);
    IP = 8'd1; tick();
    chk("t2_ip1", data_a, 16'h0C03);
    chk("t2_done_pulses", done_seen - d0, 1);

    // Partial word
    start();
    send(8'hAA); send(8'hBB); send(8'hCC);
    start();
    chk("t3_err", err_a, 1'b1);
    chk("t3_done", done_a, 1'b0);
    chk("t3_count", cnt_a, 9'd1);
    IP = 8'd0; tick();
    chk("t3_mem0", data_a, 16'hAABB);
    start();
    chk("t3_err_clr", err_a, 1'b0);
    start();

    // Overflow on the 4-deep instance; 200-deep one simply takes 5 words
    start();
    for (int i = 0; i < 10; i++) send(8'(8'h10 + i));
    chk("t4_err_b", err_b, 1'b1);
    chk("t4_busy_b", busy_b, 1'b0);
    chk("t4_count_b", cnt_b, 9'd4);
    chk("t4_count_a", cnt_a, 9'd5);
    RESET = 1'b0; #3; RESET = 1'b1;
    IP = 8'd3; tick();
    chk("t4_w3_b", data_b, 16'h1617);

    // Simultaneous start and strobe; fetch blocked during load
    IP = 8'd0;
    start();
    tick();
    chk("t5_nop_data", data_a, 16'h0000);
    chk("t5_nop_valid", valid_a, 1'b0);
    send(8'h12); send(8'h34);
    LD_START = 1'b1; LD_STB = 1'b1; LD_BYTE = 8'h55; tick();
    LD_START = 1'b0; LD_STB = 1'b0;
    chk("t5_done", done_a, 1'b1);
    chk("t5_count", cnt_a, 9'd1);
    tick();
    chk("t5_w0", data_a, 16'h1234);
    IP = 8'd1; tick();
    chk("t5_w1", data_a, 16'h1213);

    // Reset mid-load after 3 words and one byte
    start();
    for (int i = 0; i < 7; i++) send(8'(8'hA1 + i));
    RESET = 1'b0; #1;
    chk("t6_hold_a", hold_a, 1'b0);
    chk("t6_hold_b", hold_b, 1'b0);
    chk("t6_rst_data", data_a, 16'h0000);
    #3; RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      IP = 8'(i); tick();
      chk($sformatf("t6_w%0d", i), data_a, t6_exp[i]);
    end
    IP = 8'd250; tick();
    chk("t6_oor", data_a, 16'h0000);
    FETCH_EN = 1'b0; IP = 8'd1; tick();
    chk("t6_hold_valid", valid_a, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/progmem_boot.md
Name: progmem_boot

Overview:
- Parametrised synchronous program memory for MicroCPU.
- Replaces the fixed-content instruction ROM with a RAM whose contents are downloaded byte-wise through a boot-loader port.
- Serves CPU fetches with one-cycle registered latency.
- Holds the CPU (`CPU_HOLD`) while a load is in progress.

Parameters:
- `DATA_W`, 16, instruction word width in bits; must be a multiple of 8.
- `ADDR_W`, 8, width of `IP` and of the internal word-address counter.
- `DEPTH`, 256, number of instruction words; must be ≤ 2^`ADDR_W`.
- Local constant `NBYTES` = `DATA_W`/8, bytes per instruction word.

Ports:
- `CLK`  in  1  clock
- `RESET`  in  1  asynchronous, active-low reset
- `IP`  in  `ADDR_W`  fetch address from CPU
- `FETCH_EN`  in  1  fetch request, sampled on rising `CLK`
- `DATA`  out  `DATA_W`  registered instruction word
- `DATA_VALID`  out  1  `DATA` was updated by a fetch on the previous edge
- `LD_START`  in  1  single-cycle pulse; starts a load in IDLE, ends it in LOAD
- `LD_BYTE`  in  8  loader data byte
- `LD_STB`  in  1  `LD_BYTE` valid strobe, one byte per asserted cycle
- `LD_BUSY`  out  1  high while in LOAD
- `LD_DONE`  out  1  one-cycle pulse on successful load end
- `LD_ERR`  out  1  sticky error flag, cleared by the next accepted `LD_START`
- `CPU_HOLD`  out  1  stall request to the CPU; equals `LD_BUSY`
- `LD_COUNT`  out  `ADDR_W`+1  number of words written in the current or last load

Behaviour:

Reset (`RESET` low, asynchronous):
- Outputs: `DATA`=0, `DATA_VALID`=0, `LD_BUSY`=0, `CPU_HOLD`=0, `LD_DONE`=0, `LD_ERR`=0, `LD_COUNT`=0.
- State returns to IDLE; byte counter and assembly register cleared.
- Memory array is not reset.
- Reset mid-load aborts the load. Words already written stay; the partial word is lost.

FSM states:

IDLE
- `LD_START`=1 → LOAD.
  - On the same edge: word address and `LD_COUNT` cleared to 0, byte counter cleared to 0, `LD_ERR` cleared.
- `LD_STB` is ignored in IDLE.

LOAD
- Each `LD_STB` cycle shifts `LD_BYTE` into the assembly register, MSB-first (the first byte lands in bits [`DATA_W`-1:`DATA_W`-8]), and increments the byte counter.
- On the `NBYTES`-th byte:
  - the word written is the first `NBYTES`-1 assembled bytes with the current byte as the LSB;
  - it is written to mem[waddr] on that edge;
  - waddr and `LD_COUNT` increment; the byte counter returns to 0.
- Overflow: a completed word with waddr = `DEPTH`-1 is written normally. Any further `LD_STB` after that:
  - `LD_ERR`=1, state → IDLE;
  - byte discarded, no write, no `LD_DONE`.
- `LD_START`=1 ends the load (→ IDLE):
  - byte counter = 0 → `LD_DONE` pulses on the next cycle;
  - byte counter ≠ 0 → partial word discarded, `LD_ERR`=1, no `LD_DONE`.
- `LD_START` and `LD_STB` in the same cycle: `LD_START` wins and the byte is ignored.

Fetch path:
- On each edge with `FETCH_EN`=1 and state IDLE:
  - `DATA` ← mem[`IP`] if `IP` < `DEPTH`, else 0;
  - `DATA_VALID` ← 1.
- `FETCH_EN`=0 in IDLE: `DATA` holds, `DATA_VALID` ← 0.
- In LOAD: `DATA` ← 0 (NOP), `DATA_VALID` ← 0.
- Latency: `IP` presented at edge n → `DATA` valid after edge n, used by the CPU at edge n+1.
- Read-during-write cannot occur, because fetch is blocked in LOAD.

`LD_BUSY` / `CPU_HOLD`:
- Registered.
- High from the edge that enters LOAD to the edge that leaves it.

Decomposition:
- Shared package `microcpu_pkg`:
  - default `DATA_W`=16 and `ADDR_W`=8;
  - opcode constants used by the program (NOP=0, 2, 12, 13);
  - FSM state encoding localparams IDLE and LOAD.
- One sub-module, `progmem_ram`: single-port synchronous RAM (`DEPTH` × `DATA_W`) with write enable and registered read. It is inferable as block RAM.
- Loader FSM, assembly register and fetch mux live in `progmem_boot`.

Test Plan:
1. Reset then idle fetch: release `RESET` at 100 ns, `FETCH_EN`=1, `IP`=3 → `DATA_VALID` goes to 1 one cycle later. `DATA` is 0 while `RESET` is low.
2. Basic load: `LD_START`, then bytes 0x0D,0x64,0x0C,0x03 on four `LD_STB` cycles, then `LD_START`.
   - `LD_DONE` pulses once; `LD_COUNT`=2; `LD_ERR`=0; `CPU_HOLD` high for the whole load.
   - Fetch `IP`=0 → 0x0D64; fetch `IP`=1 → 0x0C03.
3. Partial word: `LD_START`, bytes 0xAA,0xBB,0xCC, then `LD_START` → `LD_ERR`=1, no `LD_DONE`, `LD_COUNT`=1, mem[0]=0xAABB. `LD_ERR` clears on the next `LD_START`.
4. Overflow with `DEPTH`=4: stream 10 bytes → words 0..3 written, `LD_ERR`=1 on the 9th byte, state IDLE, 10th byte ignored, `LD_COUNT`=4.
5. Simultaneous events: `LD_START`+`LD_STB`(0x55) in the same LOAD cycle → load ends, byte ignored. Fetch during LOAD → `DATA`=0, `DATA_VALID`=0.
6. Reset mid-load after 3 words + 1 byte → `CPU_HOLD`=0 immediately; fetches of `IP`=0..2 return the loaded words. `IP` ≥ `DEPTH` (`DEPTH`=200, `IP`=250) → `DATA`=0.
